// File: rtl/dense_layer_engine.sv
// Time-multiplexed dense layer: NUM_LANES MACs sweep NUM_NEURONS/NUM_LANES groups, saturate, then activate.
// Latency G*(NUM_INPUTS+3)+1 cycles from strobe to outputs_ready; strobes while busy are dropped.
module dense_layer_engine #(
  parameter int INT_WIDTH   = 16,
  parameter int FRAC_WIDTH  = 16,
  parameter int NUM_INPUTS  = 10,
  parameter int NUM_NEURONS = 16,
  parameter int NUM_LANES   = 4,
  parameter int ACTIVATION  = 1,
  parameter int LEAKY_SHIFT = 3,
  localparam int W  = INT_WIDTH + FRAC_WIDTH,
  localparam int G  = NUM_NEURONS / NUM_LANES,
  localparam int AW = $clog2(G * (NUM_INPUTS + 1))
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                inputs_ready,
  input  logic [NUM_INPUTS-1:0][W-1:0]        inputs,
  output logic [AW-1:0]                       weight_address,
  input  logic [NUM_LANES-1:0][W-1:0]         weight_data,
  output logic                                busy,
  output logic                                outputs_ready,
  output logic [NUM_NEURONS-1:0][W-1:0]       outputs
);

  localparam int KW    = $clog2(NUM_INPUTS + 1);
  localparam int GW    = (G > 1) ? $clog2(G) : 1;
  localparam int ACC_W = 2 * W + $clog2(NUM_INPUTS + 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;

  state_t                         state, state_next;
  logic [KW-1:0]                  k;
  logic [GW-1:0]                  g;
  logic [AW-1:0]                  addr;
  logic                           ready_q;
  logic                           start;
  logic [NUM_INPUTS-1:0][W-1:0]   inputs_q;
  logic [NUM_NEURONS-1:0][W-1:0]  outputs_q;
  logic [KW-1:0]                  in_idx;
  logic signed [W-1:0]            in_sel;
  logic signed [ACC_W-1:0]        acc      [NUM_LANES];
  logic signed [2*W-1:0]          prod     [NUM_LANES];
  logic signed [ACC_W-1:0]        bias_ext [NUM_LANES];
  logic signed [ACC_W-1:0]        shifted  [NUM_LANES];
  logic signed [W-1:0]            sat      [NUM_LANES];
  logic signed [W-1:0]            act      [NUM_LANES];

  // The outputs_ready cycle sits in IDLE but still counts as busy.
  assign start          = inputs_ready && (state == IDLE) && !ready_q;
  assign busy           = (state != IDLE) || ready_q;
  assign outputs_ready  = ready_q;
  assign outputs        = outputs_q;
  assign weight_address = (state == FETCH) ? addr : '0;

  // Memory answers one cycle late, so FETCH step k consumes the weight for input k-1.
  assign in_idx = (k == '0) ? '0 : k - KW'(1);
  assign in_sel = inputs_q[in_idx];

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   if (k == KW'(NUM_INPUTS)) state_next = DRAIN;
      DRAIN:   state_next = WRITE;
      WRITE:   state_next = (g == GW'(G - 1)) ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      prod[l]     = (2*W)'(in_sel) * (2*W)'($signed(weight_data[l]));
      bias_ext[l] = ACC_W'($signed(weight_data[l])) <<< FRAC_WIDTH;
      shifted[l]  = acc[l] >>> FRAC_WIDTH;
      // In range only when every bit above the result's sign bit matches it.
      if ((&shifted[l][ACC_W-1:W-1]) || !(|shifted[l][ACC_W-1:W-1]))
        sat[l] = shifted[l][W-1:0];
      else
        sat[l] = {shifted[l][ACC_W-1], {(W-1){~shifted[l][ACC_W-1]}}};
      if (ACTIVATION == 1 && sat[l][W-1])
        act[l] = '0;
      else if (ACTIVATION == 2 && sat[l][W-1])
        act[l] = sat[l] >>> LEAKY_SHIFT;
      else
        act[l] = sat[l];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      k         <= '0;
      g         <= '0;
      addr      <= '0;
      ready_q   <= 1'b0;
      inputs_q  <= '0;
      outputs_q <= '0;
      for (int l = 0; l < NUM_LANES; l++) acc[l] <= '0;
    end else begin
      ready_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            inputs_q <= inputs;
            k        <= '0;
            g        <= '0;
            addr     <= '0;
            for (int l = 0; l < NUM_LANES; l++) acc[l] <= '0;
          end
        end
        FETCH: begin
          addr <= addr + AW'(1);
          k    <= (k == KW'(NUM_INPUTS)) ? '0 : k + KW'(1);
          if (k != '0)
            for (int l = 0; l < NUM_LANES; l++) acc[l] <= acc[l] + ACC_W'(prod[l]);
        end
        DRAIN: begin
          for (int l = 0; l < NUM_LANES; l++) acc[l] <= acc[l] + bias_ext[l];
        end
        WRITE: begin
          for (int l = 0; l < NUM_LANES; l++) begin
            outputs_q[int'(g) * NUM_LANES + l] <= act[l];
            acc[l] <= '0;
          end
          g <= (g == GW'(G - 1)) ? '0 : g + GW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_engine.sv
// Bench for dense_layer_engine: linear, ReLU and leaky instances run in lockstep against a modelled weight ROM.
module tb_dense_layer_engine;

  localparam int W  = 32;
  localparam int NI = 10;
  localparam int NN = 16;
  localparam int L  = 4;
  localparam int AW = 6;

  typedef logic [NN-1:0][W-1:0] vec_t;
  typedef logic [NI-1:0][W-1:0] in_t;
  typedef struct packed { logic [7:0] id; vec_t lin; vec_t relu; vec_t leaky; } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic inputs_ready = 1'b0;
  in_t  inputs = '0;
  logic [AW-1:0]         wa  [3];
  logic [L-1:0][W-1:0]   wd  [3];
  logic                  bsy [3];
  logic                  rdy [3];
  vec_t                  outv[3];

  logic        wmode = 1'b0;
  logic [W-1:0] w_val = '0;
  logic [W-1:0] b_val = '0;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  initial forever #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [L-1:0][W-1:0] mem_word(input logic [AW-1:0] a);
    logic [L-1:0][W-1:0] r;
    int gi, ki;
    gi = int'(a) / (NI + 1);
    ki = int'(a) % (NI + 1);
    for (int l = 0; l < L; l++) begin
      if (ki == NI)       r[l] = b_val;
      else if (wmode)     r[l] = W'((gi * L + l) * 32'h4000);
      else                r[l] = w_val;
    end
    return r;
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) wd[i] <= mem_word(wa[i]);
  end

  dense_layer_engine #(.ACTIVATION(0)) dut_lin (
    .clock(clock), .reset(reset), .inputs_ready(inputs_ready), .inputs(inputs),
    .weight_address(wa[0]), .weight_data(wd[0]), .busy(bsy[0]),
    .outputs_ready(rdy[0]), .outputs(outv[0]));
  dense_layer_engine #(.ACTIVATION(1)) dut_relu (
    .clock(clock), .reset(reset), .inputs_ready(inputs_ready), .inputs(inputs),
    .weight_address(wa[1]), .weight_data(wd[1]), .busy(bsy[1]),
    .outputs_ready(rdy[1]), .outputs(outv[1]));
  dense_layer_engine #(.ACTIVATION(2)) dut_leaky (
    .clock(clock), .reset(reset), .inputs_ready(inputs_ready), .inputs(inputs),
    .weight_address(wa[2]), .weight_data(wd[2]), .busy(bsy[2]),
    .outputs_ready(rdy[2]), .outputs(outv[2]));

  task automatic chk(input string nm, input logic [NN*W-1:0] a, input logic [NN*W-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  function automatic vec_t fill(input logic [W-1:0] v);
    vec_t f;
    for (int n = 0; n < NN; n++) f[n] = v;
    return f;
  endfunction

  function automatic in_t fill_in(input logic [W-1:0] v);
    in_t f;
    for (int i = 0; i < NI; i++) f[i] = v;
    return f;
  endfunction

  // Monitor: every outputs_ready pulse consumes one expected result.
  always @(negedge clock) begin
    exp_t e;
    if (rdy[1]) begin
      chk("ready_lockstep", {rdy[0], rdy[2]}, 2'b11);
      if (sb.size() == 0) begin
        chk("unexpected_outputs_ready", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("job%0d_linear", e.id), outv[0], e.lin);
        chk($sformatf("job%0d_relu", e.id),   outv[1], e.relu);
        chk($sformatf("job%0d_leaky", e.id),  outv[2], e.leaky);
      end
    end
  end

  task automatic run_job(input int id, input in_t iv, input vec_t el, input vec_t er,
                         input vec_t ek, input bit glitch);
    exp_t e;
    int   n;
    bit   busy_drop;
    e.id = 8'(id); e.lin = el; e.relu = er; e.leaky = ek;
    sb.push_back(e);
    @(negedge clock);
    inputs = iv;
    inputs_ready = 1'b1;
    @(posedge clock);
    #1 inputs_ready = 1'b0;
    chk($sformatf("job%0d_busy_start", id), bsy[1], 1'b1);
    n = 0;
    busy_drop = 1'b0;
    while (n < 200) begin
      @(posedge clock);
      n++;
      #1;
      if (rdy[1]) break;
      if (!bsy[1]) busy_drop = 1'b1;
      if (glitch && n == 9) begin
        inputs_ready = 1'b1;
        inputs = ~iv;
      end else if (glitch && n == 10) begin
        inputs_ready = 1'b0;
      end
    end
    chk($sformatf("job%0d_latency", id), n, 53);
    chk($sformatf("job%0d_busy_held", id), busy_drop, 1'b0);
    chk($sformatf("job%0d_busy_at_ready", id), bsy[1], 1'b1);
    @(posedge clock);
    #1;
    chk($sformatf("job%0d_ready_width", id), rdy[1], 1'b0);
    chk($sformatf("job%0d_busy_after", id), bsy[1], 1'b0);
  endtask

  initial begin
    in_t ramp;
    vec_t tri_v;

    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", {bsy[0], bsy[1], bsy[2]}, 3'b000);
    chk("reset_ready", {rdy[0], rdy[1], rdy[2]}, 3'b000);
    chk("reset_outputs", outv[1], '0);
    chk("reset_address", wa[1], '0);
    @(negedge clock);
    reset = 1'b1;

    // 1.0 inputs, 0.5 weights: 10 * 0.5 = 5.0
    w_val = 32'h0000_8000; b_val = '0;
    run_job(1, fill_in(32'h0001_0000), fill(32'h0005_0000), fill(32'h0005_0000), fill(32'h0005_0000), 1'b0);

    // -1.0 weights: -10.0, ReLU 0, leaky -1.25
    w_val = 32'hFFFF_0000;
    run_job(2, fill_in(32'h0001_0000), fill(32'hFFF6_0000), fill(32'h0), fill(32'hFFFE_C000), 1'b0);

    // 100 * 100 * 10 saturates high; negated weights saturate low
    w_val = 32'h0064_0000;
    run_job(3, fill_in(32'h0064_0000), fill(32'h7FFF_FFFF), fill(32'h7FFF_FFFF), fill(32'h7FFF_FFFF), 1'b0);
    w_val = 32'hFF9C_0000;
    run_job(4, fill_in(32'h0064_0000), fill(32'h8000_0000), fill(32'h0), fill(32'hF000_0000), 1'b0);

    // Stray strobe at cycle 10 with other inputs must not disturb the job
    w_val = 32'h0000_8000;
    run_job(5, fill_in(32'h0001_0000), fill(32'h0005_0000), fill(32'h0005_0000), fill(32'h0005_0000), 1'b1);

    // Inputs 1..10, 0.5 weights: 27.5; issued right after the previous pulse
    for (int i = 0; i < NI; i++) ramp[i] = W'((i + 1) * 32'h0001_0000);
    run_job(6, ramp, fill(32'h001B_8000), fill(32'h001B_8000), fill(32'h001B_8000), 1'b0);

    // Bias -8.0: 5 - 8 = -3.0, leaky -0.375
    b_val = 32'hFFF8_0000;
    run_job(7, fill_in(32'h0001_0000), fill(32'hFFFD_0000), fill(32'h0), fill(32'hFFFF_A000), 1'b0);

    // Tiny products sum to -10 LSB^2; truncation rounds toward -inf to -1 LSB
    b_val = '0; w_val = 32'hFFFF_FFFF;
    run_job(8, fill_in(32'h0000_0001), fill(32'hFFFF_FFFF), fill(32'h0), fill(32'hFFFF_FFFF), 1'b0);

    // Reset in the middle of a job
    w_val = 32'h0000_8000;
    @(negedge clock);
    inputs = fill_in(32'h0001_0000);
    inputs_ready = 1'b1;
    @(posedge clock);
    #1 inputs_ready = 1'b0;
    repeat (19) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    chk("abort_busy", {bsy[0], bsy[1], bsy[2]}, 3'b000);
    chk("abort_ready", rdy[1], 1'b0);
    chk("abort_outputs", outv[1], '0);
    chk("abort_address", wa[1], '0);
    repeat (80) @(posedge clock);
    #1;
    chk("abort_outputs_idle", outv[0], '0);

    run_job(9, fill_in(32'h0001_0000), fill(32'h0005_0000), fill(32'h0005_0000), fill(32'h0005_0000), 1'b0);

    // Per-neuron weights 0.25*n: output n = 2.5*n, exposes group/lane placement
    wmode = 1'b1; b_val = '0;
    for (int n = 0; n < NN; n++) tri_v[n] = W'(n * 32'h0002_8000);
    run_job(10, fill_in(32'h0001_0000), tri_v, tri_v, tri_v, 1'b0);

    repeat (3) @(posedge clock);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
